// File: rtl/regfile_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
    localparam int unsigned ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Read/issue/write-back bundle between ID/WB (master) and the register file (slave).
interface regfile_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;
    logic [AW:0]              pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, pend_cnt
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register plus registered population count.
module rf_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int unsigned NREGS = NREGS_DEF,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] pend_d, pend_q;
    logic [AW:0]      cnt_d, cnt_q;

    // Priority: flush beats clear, and a same-cycle issue is applied last so it always survives.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else if (wr_en && wr_addr != AW'(ZERO_REG)) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_en && iss_addr != AW'(ZERO_REG)) begin
            pend_d[iss_addr] = 1'b1;
        end

        cnt_d = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending  = pend_q;
    assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with per-register pending-write scoreboard.
// Optional same-cycle write-through forwarding when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    logic [XLEN-1:0]          regs_d [NREGS];
    logic [XLEN-1:0]          regs_q [NREGS];
    logic [NREGS-1:0]         pending;
    logic                     wr_hit;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;

    assign wr_hit = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG));

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .flush    (bus.flush),
        .pending  (pending),
        .pend_cnt (bus.pend_cnt)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (bus.rd_addr[i] != AW'(ZERO_REG)) begin
                rd_data[i] = regs_q[bus.rd_addr[i]];
                rd_busy[i] = pending[bus.rd_addr[i]];
`ifdef REGFILE_SB_BYPASS_EN
                // Forwarded write retires the hazard unless a newer producer issues to it now.
                if (wr_hit && bus.wr_addr == bus.rd_addr[i]) begin
                    rd_data[i] = bus.wr_data;
                    rd_busy[i] = bus.iss_en && (bus.iss_addr == bus.rd_addr[i]);
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.rd_busy = rd_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed test-plan scenarios plus randomized traffic.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    xword_t mem  [32];
    bit     pend [32];
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(pend[i]);
        return n;
    endfunction

    function automatic xword_t exp_data(input reg_addr_t a);
        if (a == 0) return '0;
        if (BYP && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return mem[a];
    endfunction

    function automatic bit exp_busy(input reg_addr_t a);
        if (a == 0) return 1'b0;
        if (BYP && bus.wr_en && bus.wr_addr == a) return bus.iss_en && bus.iss_addr == a;
        return pend[a];
    endfunction

    task automatic drive(input bit we, input reg_addr_t wa, input xword_t wd,
                         input bit ie, input reg_addr_t ia, input bit fl,
                         input reg_addr_t r0, input reg_addr_t r1);
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.iss_en     = ie;
        bus.iss_addr   = ia;
        bus.flush      = fl;
        bus.rd_addr[0] = r0;
        bus.rd_addr[1] = r1;
    endtask

    task automatic idle(input reg_addr_t r0, input reg_addr_t r1);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, r0, r1);
    endtask

    // Called at a negedge with inputs already applied; checks outputs, then advances one edge.
    task automatic cycle();
        #2;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("rd_data[%0d] a=%0d", p, bus.rd_addr[p]),
                  64'(bus.rd_data[p]), 64'(exp_data(bus.rd_addr[p])));
            check($sformatf("rd_busy[%0d] a=%0d", p, bus.rd_addr[p]),
                  64'(bus.rd_busy[p]), 64'(exp_busy(bus.rd_addr[p])));
        end
        check("pend_cnt", 64'(bus.pend_cnt), 64'(model_cnt()));
        @(posedge clk);
        if (bus.wr_en && bus.wr_addr != 0) mem[bus.wr_addr] = bus.wr_data;
        if (bus.flush) begin
            for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        end else if (bus.wr_en && bus.wr_addr != 0) begin
            pend[bus.wr_addr] = 1'b0;
        end
        if (bus.iss_en && bus.iss_addr != 0) pend[bus.iss_addr] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        idle('0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        idle(5'd3, 5'd31);
        #1;
        check("reset pend_cnt", 64'(bus.pend_cnt), 64'd0);
        check("reset rd_data x3", 64'(bus.rd_data[0]), 64'd0);
        cycle();

        // Write then read back on two ports
        drive(1'b1, 5'd5, 32'h0000_0008, 1'b0, '0, 1'b0, 5'd5, 5'd31);
        cycle();
        drive(1'b1, 5'd31, 32'hAAAA_AAAA, 1'b0, '0, 1'b0, 5'd5, 5'd31);
        cycle();
        idle(5'd5, 5'd31);
        #1;
        check("read x5", 64'(bus.rd_data[0]), 64'h0000_0008);
        check("read x31", 64'(bus.rd_data[1]), 64'hAAAA_AAAA);
        cycle();

        // Issue x7, write it back two cycles later
        drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
        cycle();
        idle(5'd7, 5'd0);
        #1;
        check("x7 busy after issue", 64'(bus.rd_busy[0]), 64'd1);
        check("pend_cnt after issue", 64'(bus.pend_cnt), 64'd1);
        cycle();
        drive(1'b1, 5'd7, 32'h5555_5555, 1'b0, '0, 1'b0, 5'd7, 5'd0);
        cycle();
        idle(5'd7, 5'd0);
        #1;
        check("x7 busy after wb", 64'(bus.rd_busy[0]), 64'd0);
        check("pend_cnt after wb", 64'(bus.pend_cnt), 64'd0);
        check("x7 data after wb", 64'(bus.rd_data[0]), 64'h5555_5555);
        cycle();

        // Same-cycle issue and write to a pending register: set wins
        drive(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
        cycle();
        drive(1'b1, 5'd9, 32'h0000_1234, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
        cycle();
        idle(5'd9, 5'd0);
        #1;
        check("x9 still busy", 64'(bus.rd_busy[0]), 64'd1);
        check("pend_cnt x9 collide", 64'(bus.pend_cnt), 64'd1);
        check("x9 data", 64'(bus.rd_data[0]), 64'h0000_1234);
        cycle();
        drive(1'b1, 5'd9, 32'h0000_1234, 1'b0, '0, 1'b0, 5'd9, 5'd0);
        cycle();

        // Flush with a surviving same-cycle issue
        for (int r = 1; r <= 3; r++) begin
            drive(1'b0, '0, '0, 1'b1, reg_addr_t'(r), 1'b0, 5'd1, 5'd4);
            cycle();
        end
        idle(5'd1, 5'd4);
        #1;
        check("pend_cnt before flush", 64'(bus.pend_cnt), 64'd3);
        drive(1'b1, 5'd2, 32'h77, 1'b1, 5'd4, 1'b1, 5'd1, 5'd4);
        cycle();
        idle(5'd1, 5'd4);
        #1;
        check("x1 busy after flush", 64'(bus.rd_busy[0]), 64'd0);
        check("x4 busy after flush", 64'(bus.rd_busy[1]), 64'd1);
        check("pend_cnt after flush", 64'(bus.pend_cnt), 64'd1);
        cycle();
        drive(1'b1, 5'd4, 32'h44, 1'b0, '0, 1'b0, 5'd4, 5'd2);
        cycle();

        // Same-cycle write/read of x10
        drive(1'b1, 5'd10, 32'h0000_0003, 1'b0, '0, 1'b0, 5'd10, 5'd0);
        cycle();
        drive(1'b1, 5'd10, 32'h0000_0009, 1'b0, '0, 1'b0, 5'd10, 5'd10);
        #1;
        check("x10 same-cycle read", 64'(bus.rd_data[0]), BYP ? 64'h9 : 64'h3);
        cycle();
        idle(5'd10, 5'd0);
        #1;
        check("x10 next-cycle read", 64'(bus.rd_data[0]), 64'h9);
        cycle();

        // Randomized traffic concentrated on a few registers to force collisions
        for (int n = 0; n < 400; n++) begin
            reg_addr_t wa, ia, r0, r1;
            wa = ($urandom % 4 == 0) ? reg_addr_t'($urandom_range(0, 31)) : reg_addr_t'($urandom_range(0, 7));
            ia = ($urandom % 4 == 0) ? reg_addr_t'($urandom_range(0, 31)) : reg_addr_t'($urandom_range(0, 7));
            r0 = ($urandom % 2 == 0) ? wa : reg_addr_t'($urandom_range(0, 7));
            r1 = ($urandom % 2 == 0) ? ia : reg_addr_t'($urandom_range(0, 31));
            drive(1'($urandom % 2), wa, $urandom, 1'($urandom % 2), ia,
                  ($urandom % 16 == 0), r0, r1);
            cycle();
        end

        // Asynchronous reset mid-run discards outstanding issues and data
        drive(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd5);
        cycle();
        idle(5'd7, 5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset pend_cnt", 64'(bus.pend_cnt), 64'd0);
        check("async reset x7 data", 64'(bus.rd_data[0]), 64'd0);
        check("async reset x7 busy", 64'(bus.rd_busy[0]), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            idle(reg_addr_t'(a), reg_addr_t'(31 - a));
            #1;
            check($sformatf("post-reset x%0d", a), 64'(bus.rd_data[0]), 64'd0);
            cycle();
        end

        // x0 ignores writes and issues
        drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        cycle();
        idle(5'd0, 5'd0);
        #1;
        check("x0 read", 64'(bus.rd_data[0]), 64'd0);
        check("x0 busy", 64'(bus.rd_busy[1]), 64'd0);
        check("x0 pend_cnt", 64'(bus.pend_cnt), 64'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
